// File: rtl/folded_iir_pkg.sv
// Shared definitions for the folded IIR filter: FSM encodings, default lag list,
// and the saturation / lag-extraction helpers.
package folded_iir_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [15:0] LAGS_DEFAULT = {8'd5, 8'd3};

  function automatic logic [7:0] lag_of(input logic [63:0] lags, input logic [31:0] k);
    logic [63:0] sh;
    sh = lags >> (k * 32'd8);
    return sh[7:0];
  endfunction

  // Returns {sat_flag, clamped value}; the caller keeps the low w bits.
  function automatic logic [64:0] sat_w(input logic signed [127:0] v, input logic [31:0] w);
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = (128'sd1 <<< (w - 32'd1)) - 128'sd1;
    lo = -(128'sd1 <<< (w - 32'd1));
    if (v > hi) begin
      return {1'b1, hi[63:0]};
    end else if (v < lo) begin
      return {1'b1, lo[63:0]};
    end else begin
      return {1'b0, v[63:0]};
    end
  endfunction

endpackage

// File: rtl/iir_hist_ram.sv
// Output history buffer: DEPTH x W, asynchronous read, synchronous write,
// flushed to zero by reset or by a synchronous clear.
module iir_hist_ram #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_r [DEPTH];

  // Storage update: reset and clear both zero every entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/folded_iir_k.sv
// Folded feedback IIR: one shared multiplier and accumulator walk the NTAP
// taps in consecutive cycles, then the saturated result is held until taken.
module folded_iir_k
  import folded_iir_pkg::*;
#(
  parameter int              W     = 16,
  parameter int              FRAC  = 8,
  parameter int              NTAP  = 2,
  parameter logic [NTAP*8-1:0] LAGS = LAGS_DEFAULT,
  parameter int              DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      Xn,
  input  logic [NTAP*W-1:0] coef,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      Yn,
  output logic              sat
);

  localparam int ACCW = 2 * W + $clog2(NTAP + 1);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(NTAP);

  logic [1:0]              state_r;
  logic [CW-1:0]           cnt_r;
  logic signed [ACCW-1:0]  acc_r;
  logic [NTAP*W-1:0]       coef_r;
  logic [AW-1:0]           wptr_r;
  logic [W-1:0]            yn_r;
  logic                    sat_r;
  logic                    out_valid_r;
  logic                    in_ready_r;

  logic [7:0]              lag_s;
  logic [31:0]             rd_sum_s;
  logic [AW-1:0]           rd_idx_s;
  logic [W-1:0]            hist_rd_s;
  logic signed [W-1:0]     coef_sel_s;
  logic signed [2*W-1:0]   prod_s;
  logic signed [ACCW-1:0]  acc_nxt_s;
  logic signed [ACCW-1:0]  shifted_s;
  logic signed [ACCW-1:0]  x_load_s;
  logic [64:0]             sat_res_s;
  logic                    accept_s;
  logic                    last_tap_s;
  logic                    hist_we_s;
  logic                    unused_sat_s;

  assign in_ready   = in_ready_r && !clear;
  assign out_valid  = out_valid_r;
  assign Yn         = yn_r;
  assign sat        = sat_r;
  assign accept_s   = (state_r == IDLE) && in_valid && in_ready;
  assign last_tap_s = (cnt_r == CW'(NTAP - 1));
  assign hist_we_s  = out_valid_r && out_ready && !clear;

  // Tap datapath: history index, the single shared multiplier, accumulate and saturate.
  always_comb begin
    lag_s    = lag_of(64'(LAGS), 32'(cnt_r));
    rd_sum_s = 32'(wptr_r) + 32'(DEPTH) - 32'(lag_s);
    if (rd_sum_s >= 32'(DEPTH)) begin
      rd_sum_s = rd_sum_s - 32'(DEPTH);
    end else begin
      rd_sum_s = rd_sum_s;
    end
    rd_idx_s   = rd_sum_s[AW-1:0];
    coef_sel_s = coef_r[cnt_r * W +: W];
    prod_s     = coef_sel_s * $signed(hist_rd_s);
    acc_nxt_s  = acc_r + ACCW'(prod_s);
    shifted_s  = acc_nxt_s >>> FRAC;
    sat_res_s  = sat_w(128'(shifted_s), 32'(W));
    x_load_s   = ACCW'($signed(Xn)) <<< FRAC;
  end

  assign unused_sat_s = ^sat_res_s[63:W];

  iir_hist_ram #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_hist (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .we    (hist_we_s),
    .waddr (wptr_r),
    .wdata (yn_r),
    .raddr (rd_idx_s),
    .rdata (hist_rd_s)
  );

  // Control FSM and result registers; clear aborts any sample in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      acc_r       <= '0;
      coef_r      <= '0;
      wptr_r      <= '0;
      yn_r        <= '0;
      sat_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
    end else if (clear) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      acc_r       <= '0;
      wptr_r      <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            acc_r      <= x_load_s;
            coef_r     <= coef;
            cnt_r      <= '0;
            in_ready_r <= 1'b0;
            state_r    <= MAC;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        MAC: begin
          acc_r <= acc_nxt_s;
          if (last_tap_s) begin
            yn_r        <= sat_res_s[W-1:0];
            sat_r       <= sat_res_s[64];
            out_valid_r <= 1'b1;
            state_r     <= HOLD;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
            if (wptr_r == AW'(DEPTH - 1)) begin
              wptr_r <= '0;
            end else begin
              wptr_r <= wptr_r + AW'(1);
            end
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_folded_iir_k.sv
// Directed bench for folded_iir_k (W=16, FRAC=8, NTAP=2, LAGS={5,3}, DEPTH=8).
module tb_folded_iir_k;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] Xn = 16'd0;
  logic [31:0] coef = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] Yn;
  logic        sat;

  int n_cmp = 0;
  int n_bad = 0;

  folded_iir_k #(.W(16), .FRAC(8), .NTAP(2), .LAGS({8'd5, 8'd3}), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .Xn(Xn), .coef(coef), .out_valid(out_valid), .out_ready(out_ready),
    .Yn(Yn), .sat(sat)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_sample(input logic [15:0] x, input logic [31:0] c);
    for (int i = 0; i < 20 && in_ready !== 1'b1; i++) @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL start_ready: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1; Xn = x; coef = c;
    @(negedge clk);
    in_valid = 1'b0; Xn = 16'hA5A5; coef = 32'h7F3C_8001;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_out;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic pulse_clear;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (Yn !== 16'd0) begin n_bad++; $display("FAIL reset_yn: got %0d want 0", Yn); end
    n_cmp++; if (sat !== 1'b0) begin n_bad++; $display("FAIL reset_sat: got %b want 0", sat); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL pre_clock_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL first_clock_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_impulse(input string tag);
    logic [15:0] y_exp [7] = '{16'd256, 16'd0, 16'd0, 16'd128, 16'd0, 16'd64, 16'd64};
    int lat;
    for (int n = 0; n < 7; n++) begin
      start_sample((n == 0) ? 16'd256 : 16'd0, {16'd64, 16'd128});
      wait_out(lat);
      n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL %s_latency[%0d]: got %0d want 3", tag, n, lat); end
      n_cmp++; if (Yn !== y_exp[n]) begin n_bad++; $display("FAIL %s_y[%0d]: got %0d want %0d", tag, n, Yn, y_exp[n]); end
      n_cmp++; if (sat !== 1'b0) begin n_bad++; $display("FAIL %s_sat[%0d]: got %b want 0", tag, n, sat); end
      finish_out();
    end
  endtask

  task automatic test_saturation;
    logic s_exp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int lat;
    pulse_clear();
    for (int n = 0; n < 4; n++) begin
      start_sample(16'h7FFF, {16'd0, 16'd256});
      wait_out(lat);
      n_cmp++; if (Yn !== 16'h7FFF) begin n_bad++; $display("FAIL sat_y[%0d]: got %0d want 32767", n, Yn); end
      n_cmp++; if (sat !== s_exp[n]) begin n_bad++; $display("FAIL sat_flag[%0d]: got %b want %b", n, sat, s_exp[n]); end
      finish_out();
    end
  endtask

  task automatic test_backpressure;
    int lat;
    pulse_clear();
    start_sample(16'd100, 32'd0);
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || Yn !== 16'd100 || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: out_valid=%b Yn=%0d in_ready=%b want 1/100/0", i, out_valid, Yn, in_ready);
      end
      @(negedge clk);
    end
    n_cmp++; if (out_valid !== 1'b1 || Yn !== 16'd100) begin n_bad++; $display("FAIL bp_sixth: out_valid=%b Yn=%0d want 1/100", out_valid, Yn); end
    finish_out();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_abort;
    bit seen;
    start_sample(16'd256, {16'd64, 16'd128});
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || Yn !== 16'd0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL abort_reset: out_valid=%b Yn=%0d in_ready=%b want 0/0/0", out_valid, Yn, in_ready); end
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL abort_no_output: out_valid seen=1 want 0"); end
    test_impulse("abort_impulse");
  endtask

  task automatic test_clear;
    bit seen;
    int lat;
    logic [15:0] xs [4] = '{16'd300, 16'd0, 16'd0, 16'd0};
    logic [15:0] ys [4] = '{16'd300, 16'd0, 16'd0, 16'd150};
    clear = 1'b1; in_valid = 1'b1; Xn = 16'd500; coef = {16'd64, 16'd128};
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL clear_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL clear_not_accepted: out_valid seen=1 want 0"); end
    for (int n = 0; n < 4; n++) begin
      start_sample(xs[n], {16'd64, 16'd128});
      wait_out(lat);
      n_cmp++; if (Yn !== ys[n]) begin n_bad++; $display("FAIL clear_y[%0d]: got %0d want %0d", n, Yn, ys[n]); end
      finish_out();
    end
  endtask

  task automatic test_wrap;
    longint yq[$];
    pulse_clear();
    for (int n = 0; n < 20; n++) begin
      logic [15:0] x;
      logic [15:0] c0;
      logic [15:0] c1;
      logic [15:0] ye;
      logic        se;
      int          ci;
      int          xi;
      int          lat;
      longint      acc;
      xi = int'($urandom_range(0, 32767)) - 16384;
      x  = xi[15:0];
      ci = int'($urandom_range(0, 512)) - 256;
      c0 = ci[15:0];
      ci = int'($urandom_range(0, 512)) - 256;
      c1 = ci[15:0];
      acc = longint'($signed(x)) <<< 8;
      if (n >= 3) acc = acc + longint'($signed(c0)) * yq[n - 3];
      if (n >= 5) acc = acc + longint'($signed(c1)) * yq[n - 5];
      acc = acc >>> 8;
      if (acc > 64'sd32767) begin
        ye = 16'h7FFF; se = 1'b1;
      end else if (acc < -64'sd32768) begin
        ye = 16'h8000; se = 1'b1;
      end else begin
        ye = acc[15:0]; se = 1'b0;
      end
      yq.push_back(longint'($signed(ye)));
      start_sample(x, {c1, c0});
      wait_out(lat);
      n_cmp++; if (Yn !== ye) begin n_bad++; $display("FAIL wrap_y[%0d]: got %0d want %0d", n, $signed(Yn), $signed(ye)); end
      n_cmp++; if (sat !== se) begin n_bad++; $display("FAIL wrap_sat[%0d]: got %b want %b", n, sat, se); end
      finish_out();
    end
  endtask

  initial begin
    test_reset();
    test_impulse("impulse");
    test_saturation();
    test_backpressure();
    test_abort();
    test_clear();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/folded_iir_k.md
FOLDED_IIR_K -- requirements
Module: folded_iir_k

Interface
REQ-001 SHALL have parameter W, default 16, meaning sample and coefficient width (signed two's complement).
REQ-002 SHALL have parameter FRAC, default 8, meaning coefficient fraction bits (Q(W-FRAC).FRAC).
REQ-003 SHALL have parameter NTAP, default 2, meaning number of feedback taps, which is also the folding factor (2..8).
REQ-004 SHALL have parameter LAGS, default {8'd5,8'd3}, meaning packed NTAP x 8-bit lag list with tap k in bits [8k+7:8k], each lag 1..DEPTH.
REQ-005 SHALL have parameter DEPTH, default 8, meaning history buffer entries (>= max lag).
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, asynchronous and active-low.
REQ-008 clear  in  1  synchronous history flush.
REQ-009 in_valid  in  1  Xn present; in_ready  out  1  block can accept.
REQ-010 Xn  in  W  signed input sample.
REQ-011 coef  in  NTAP*W  signed coefficients, tap k in bits [Wk+W-1:Wk].
REQ-012 out_valid  out  1  Yn valid; out_ready  in  1  downstream accepts.
REQ-013 Yn  out  W  signed output sample; sat  out  1  Yn was saturated.

Function
REQ-014 SHALL compute Y[n] = sat_W( ( (X[n]<<FRAC) + sum_k coef_k*Y[n-LAG_k] ) >>> FRAC ), with Y[m]=0 for m before reset or clear.
REQ-015 SHALL use exactly one W x W signed multiplier and one accumulator adder, time-shared over NTAP cycles.
REQ-016 Accumulator SHALL be 2W+clog2(NTAP+1) bits, with no intermediate overflow; >>> SHALL be arithmetic shift (truncate toward minus infinity).
REQ-017 sat_W SHALL clamp to [-2^(W-1), 2^(W-1)-1] and set sat=1 when clamping occurs, else 0; sat SHALL be valid with out_valid.
REQ-018 FSM states SHALL be IDLE, MAC, HOLD.
REQ-019 IDLE: in_ready=1; on in_valid&&in_ready, latch Xn and coef, load acc=Xn<<FRAC, set tap counter=0, and go to MAC.
REQ-020 MAC: one tap per cycle; read history[(wptr-LAG_k) mod DEPTH], acc+=coef_k*value; after tap NTAP-1, go to HOLD.
REQ-021 Latency: if a sample is accepted in cycle t, out_valid SHALL rise in cycle t+NTAP+1; throughput SHALL be one sample per NTAP+1 cycles at most.
REQ-022 HOLD: out_valid=1, with Yn and sat stable until out_ready; in_ready=0 in MAC and HOLD.
REQ-023 On out_valid&&out_ready, Yn SHALL be written to history[wptr], wptr SHALL increment modulo DEPTH (wrap DEPTH-1 to 0), and the FSM SHALL go to IDLE.
REQ-024 Coefficient or Xn changes after acceptance SHALL NOT affect the sample in flight.
REQ-025 clear SHALL zero all history, reset wptr=0, abort any in-flight sample without out_valid, force IDLE, and hold in_ready=0 in the same cycle.
REQ-026 clear SHALL take priority over simultaneous in_valid or out_ready.
REQ-027 Yn SHALL hold its last value when out_valid=0.

Reset
REQ-028 rst=0 SHALL asynchronously force IDLE, wptr=0, history=0, acc=0, counter=0, Yn=0, sat=0, out_valid=0, in_ready=0.
REQ-029 in_ready SHALL go to 1 in the first clock after rst deasserts.
REQ-030 Reset mid-MAC or mid-HOLD SHALL discard the sample, with no output produced.

Structure
REQ-031 Package folded_iir_pkg SHALL hold the state enum (IDLE/MAC/HOLD), the sat_W and lag-extraction functions, and the default LAGS constant.
REQ-032 The history buffer SHALL be a sub-module iir_hist_ram (DEPTH x W, one async read port, one write port, synchronous clear); the multiplier SHALL stay inline.

Verification
REQ-033 Impulse test: NTAP=2, LAGS={5,3}, FRAC=8, coef a=128 (0.5), b=64 (0.25), X=256,0,0,... -> Y0..Y6 = 256,0,0,128,0,64,64.
REQ-034 Saturation test: coef a=256, b=0, X=0x7FFF constant -> Y0..Y2=32767 with sat=0; Y3=32767 with sat=1.
REQ-035 Backpressure test: out_ready held low 5 cycles in HOLD -> out_valid=1, Yn stable, in_ready=0 throughout; accepted on cycle 6.
REQ-036 Abort test: rst pulsed low during MAC tap 1 -> no out_valid; next impulse reproduces REQ-033 from Y0.
REQ-037 Clear test: clear asserted together with in_valid in IDLE -> sample not accepted, history zero; the following sample gives Y=X.
REQ-038 Wrap test: DEPTH=8, 20 samples with random X/coef -> Yn bit-exact against a reference model, including all pointer wraps.
